fft_twiddle_derotator: RTL and testbench
========================================

// Module: fft_twiddle_derotator
// PURPOSE
//  Receiver-side (FFT) counterpart of the transmit IFFT constant-twiddle multiplier: rotates each complex
//  sample by e^(-j*k*pi/4), k = rot_sel (0..7), i.e. the trivial radix-8 FFT twiddles, using one shared
//  1/sqrt2 constant multiply. Streaming, 3-stage pipeline with valid/ready backpressure, round + saturate.
//  Sits between FFT butterfly stages in the OFDM baseband receiver path.
// PARAMETERS
//  Data_Width  32  signed two's-complement width of each I/Q component (in and out)
//  Coef_Width  16  width of constant C = round(2^(Coef_Width-1)/sqrt2) (23170 at default)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           reset, synchronous, active-high
//  Real_in    in   Data_Width  signed real part a of input sample
//  Imag_in    in   Data_Width  signed imaginary part b of input sample
//  rot_sel    in   3           k: rotation by e^(-j*k*pi/4), travels with the sample
//  in_valid   in   1           input sample valid
//  in_ready   out  1           block accepts sample when in_valid & in_ready
//  Real_out   out  Data_Width  signed real part of rotated sample
//  Imag_out   out  Data_Width  signed imaginary part of rotated sample
//  out_valid  out  1           output sample valid
//  out_ready  in   1           downstream accepts when out_valid & out_ready
//  sat        out  1           this output sample saturated in either component (qualified by out_valid)
// BEHAVIOUR
//  Reset (rst=1 at edge): all stage valids, out_valid, sat, Real_out, Imag_out -> 0; in-flight samples
//   discarded; reset wins over any simultaneous handshake. Output one cycle after rst deasserts: idle.
//  Pipeline enable en = ~out_valid | out_ready; in_ready = en (combinational). When en=0 every stage
//   holds (data + valid); when en=1 all stages advance together. Bubbles advance as invalid stages.
//  Latency: accepted sample appears on out_valid exactly 3 cycles later with no stall; +1 per stalled cycle.
//  Ordering strictly preserved; no sample dropped or duplicated under any out_ready pattern.
//  Output regs hold value while out_valid & ~out_ready.
//  Stage 1: register s = a+b, d = a-b at Data_Width+1 bits (no overflow), plus a, b, k, valid.
//  Stage 2: Ps = (s*C + 2^(Coef_Width-2)) >>> (Coef_Width-1), Pd likewise from d (round half up,
//   arithmetic shift); full-precision product, no intermediate truncation. a, b, k, valid delayed.
//  Stage 3: select per k, then saturate to [-2^(Data_Width-1), 2^(Data_Width-1)-1]:
//   k=0: (a, b)   k=2: (b, -a)   k=4: (-a, -b)   k=6: (-b, a)
//   k=1: (Ps, -Pd) k=3: (-Pd, -Ps) k=5: (-Ps, Pd) k=7: (Pd, Ps)
//   Negation computed at Data_Width+2 bits before saturation (so -(-2^(W-1)) saturates to max).
//   sat = 1 if either component clipped; registered with the data, same valid.
//  No internal FSM beyond per-stage valid bits; no state survives reset.
// TESTING (Data_Width=16, Coef_Width=16, C=23170)
//  1 k=0, a=1000,b=-200, out_ready=1 -> 3 cycles later out (1000,-200), sat=0; in_ready stays 1.
//  2 k=1, a=1000,b=0 -> (707,-707); k=2 same input -> (0,-1000); k=6 -> (0,1000).
//  3 k=4, a=-32768,b=5 -> (32767,-5), sat=1; k=7, a=b=32767 -> (0,32767), sat=1.
//  4 Backpressure: stream 6 samples (k cycling 0..7), out_ready=0 for 5 cycles -> in_ready low once 3
//    held, outputs frozen; release -> all 6 exit in order, values match model, none lost/duplicated.
//  5 Random out_ready (50%) + random in_valid, 10k samples, all k incl. -32768/32767 corners
//    -> bit-exact vs reference model, order preserved, sat matches model.
//  6 rst=1 for 1 cycle with 3 samples in flight and out_valid=1 -> next cycle out_valid=0, outputs 0;
//    no stale sample emitted; new sample after reset returns after 3 cycles.

Source files
------------

// File: rtl/fft_twiddle_derotator.sv
// -----------------------------------------------------------------------------
// fft_twiddle_derotator
//
// Purpose
//   Receive-side constant-twiddle rotator placed between FFT butterfly stages.
//   Each complex sample (a + jb) is rotated by e^(-j*k*pi/4), where k = rot_sel
//   travels alongside the sample. The odd k rotations need the 1/sqrt2 factor.
//   This is obtained from one shared pair of constant multiplies on s = a+b and
//   d = a-b:
//     Ps = round(s * C / 2^(Coef_Width-1)),  Pd = round(d * C / 2^(Coef_Width-1))
//   where C = round(2^(Coef_Width-1)/sqrt2).
//   Results are rounded half-up, arithmetic-shifted and saturated to
//   Data_Width bits.
//
// Pipeline
//   stage 1 : s, d (Data_Width+1 bits), a, b, k, valid
//   stage 2 : Ps, Pd rounded products,   a, b, k, valid
//   stage 3 : output registers (selected/negated/saturated value, sat, valid)
//
// Handshake (valid/ready)
//   A sample moves on a rising edge where valid & ready are both high. The
//   whole pipeline shares one enable, en = ~out_valid | out_ready. in_ready is
//   that enable, combinationally. When en is low every stage holds its data
//   and valid bit. When en is high all stages shift by one, so empty slots
//   move forward as invalid stages. The output holds steady while
//   out_valid & ~out_ready.
//
// Ports
//   clk        in   1           clock, rising edge
//   rst        in   1           synchronous active-high reset, clears every stage
//   Real_in    in   Data_Width  signed real part a
//   Imag_in    in   Data_Width  signed imaginary part b
//   rot_sel    in   3           k, rotation by e^(-j*k*pi/4)
//   in_valid   in   1           input sample valid
//   in_ready   out  1           input accepted when in_valid & in_ready
//   Real_out   out  Data_Width  signed rotated real part
//   Imag_out   out  Data_Width  signed rotated imaginary part
//   out_valid  out  1           output sample valid
//   out_ready  in   1           downstream accepts when out_valid & out_ready
//   sat        out  1           either output component was clipped
// -----------------------------------------------------------------------------
module fft_twiddle_derotator #(
  parameter int Data_Width = 32,
  parameter int Coef_Width = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [Data_Width-1:0] Real_in,
  input  logic [Data_Width-1:0] Imag_in,
  input  logic [2:0]            rot_sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [Data_Width-1:0] Real_out,
  output logic [Data_Width-1:0] Imag_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  sat
);

  localparam int W  = Data_Width;
  localparam int WS = W + 1;      // sum/difference width, cannot overflow
  localparam int WN = W + 2;      // width for negation ahead of saturation
  localparam int CW = Coef_Width;
  localparam int PW = WS + CW;    // full-precision product width

  // C = round(2^(CW-1)/sqrt2) = round(sqrt(2^(2*CW-3))), which is computed as
  // an integer square root. The result is then rounded to nearest: round up
  // when n - x^2 > x.
  function automatic longint round_sqrt_pow2(input int e);
    longint n;
    longint lo;
    longint hi;
    longint mid;
    n  = longint'(1) <<< e;
    lo = 0;
    hi = longint'(1) <<< (e / 2 + 1);
    for (int i = 0; i < 64; i++) begin
      if (lo < hi) begin
        mid = (lo + hi + 1) >>> 1;
        if (mid * mid <= n) lo = mid;
        else                hi = mid - 1;
      end
    end
    if (n - lo * lo > lo) lo = lo + 1;
    return lo;
  endfunction

  localparam longint                 C_FULL = round_sqrt_pow2(2 * CW - 3);
  localparam logic signed [CW-1:0]   C      = C_FULL[CW-1:0];
  localparam logic signed [PW-1:0]   C_X    = PW'(C);
  localparam logic signed [PW-1:0]   RND    = PW'(1) <<< (CW - 2);

  // ---------------------------------------------------------------------------
  // Shared pipeline enable
  // ---------------------------------------------------------------------------
  logic w_en;
  logic r_out_valid;

  assign w_en     = ~r_out_valid | out_ready;
  assign in_ready = w_en;

  // ---------------------------------------------------------------------------
  // Stage 1: sum and difference
  // ---------------------------------------------------------------------------
  logic signed [WS-1:0] w_a_x;
  logic signed [WS-1:0] w_b_x;

  assign w_a_x = WS'($signed(Real_in));
  assign w_b_x = WS'($signed(Imag_in));

  logic                 r_s1_v;
  logic signed [W-1:0]  r_s1_a;
  logic signed [W-1:0]  r_s1_b;
  logic signed [WS-1:0] r_s1_s;
  logic signed [WS-1:0] r_s1_d;
  logic [2:0]           r_s1_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s1_a <= '0;
      r_s1_b <= '0;
      r_s1_s <= '0;
      r_s1_d <= '0;
      r_s1_k <= '0;
    end else if (w_en) begin
      r_s1_v <= in_valid;
      r_s1_a <= $signed(Real_in);
      r_s1_b <= $signed(Imag_in);
      r_s1_s <= w_a_x + w_b_x;
      r_s1_d <= w_a_x - w_b_x;
      r_s1_k <= rot_sel;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: constant multiply, round half up, arithmetic shift
  // ---------------------------------------------------------------------------
  logic signed [PW-1:0] w_prod_s;
  logic signed [PW-1:0] w_prod_d;
  logic signed [PW-1:0] w_rnd_s;
  logic signed [PW-1:0] w_rnd_d;
  logic signed [WS-1:0] w_ps;
  logic signed [WS-1:0] w_pd;

  assign w_prod_s = PW'(r_s1_s) * C_X;
  assign w_prod_d = PW'(r_s1_d) * C_X;
  assign w_rnd_s  = w_prod_s + RND;
  assign w_rnd_d  = w_prod_d + RND;
  // Taking bits [CW-1 +: WS] is the arithmetic shift by CW-1. |Ps| < 2^W, so
  // the dropped top bit is always a copy of the sign.
  assign w_ps     = w_rnd_s[CW-1 +: WS];
  assign w_pd     = w_rnd_d[CW-1 +: WS];

  logic w_unused;
  assign w_unused = ^{w_rnd_s[CW-2:0], w_rnd_d[CW-2:0], w_rnd_s[PW-1], w_rnd_d[PW-1]};

  logic                 r_s2_v;
  logic signed [W-1:0]  r_s2_a;
  logic signed [W-1:0]  r_s2_b;
  logic signed [WS-1:0] r_s2_ps;
  logic signed [WS-1:0] r_s2_pd;
  logic [2:0]           r_s2_k;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_v  <= 1'b0;
      r_s2_a  <= '0;
      r_s2_b  <= '0;
      r_s2_ps <= '0;
      r_s2_pd <= '0;
      r_s2_k  <= '0;
    end else if (w_en) begin
      r_s2_v  <= r_s1_v;
      r_s2_a  <= r_s1_a;
      r_s2_b  <= r_s1_b;
      r_s2_ps <= w_ps;
      r_s2_pd <= w_pd;
      r_s2_k  <= r_s1_k;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: select per k, negate at W+2 bits, saturate, register
  // ---------------------------------------------------------------------------
  logic signed [WN-1:0] w_a_n;
  logic signed [WN-1:0] w_b_n;
  logic signed [WN-1:0] w_ps_n;
  logic signed [WN-1:0] w_pd_n;
  logic signed [WN-1:0] w_re_n;
  logic signed [WN-1:0] w_im_n;

  assign w_a_n  = WN'(r_s2_a);
  assign w_b_n  = WN'(r_s2_b);
  assign w_ps_n = WN'(r_s2_ps);
  assign w_pd_n = WN'(r_s2_pd);

  always_comb begin
    w_re_n = w_a_n;
    w_im_n = w_b_n;
    case (r_s2_k)
      3'd0: begin w_re_n =  w_a_n;  w_im_n =  w_b_n;  end
      3'd1: begin w_re_n =  w_ps_n; w_im_n = -w_pd_n; end
      3'd2: begin w_re_n =  w_b_n;  w_im_n = -w_a_n;  end
      3'd3: begin w_re_n = -w_pd_n; w_im_n = -w_ps_n; end
      3'd4: begin w_re_n = -w_a_n;  w_im_n = -w_b_n;  end
      3'd5: begin w_re_n = -w_ps_n; w_im_n =  w_pd_n; end
      3'd6: begin w_re_n = -w_b_n;  w_im_n =  w_a_n;  end
      default: begin w_re_n = w_pd_n; w_im_n = w_ps_n; end
    endcase
  end

  // {clipped, value}. The value is in range when the top three bits
  // [WN-1:W-1] agree. Otherwise it clips toward its sign.
  function automatic logic [W:0] clip(input logic signed [WN-1:0] v);
    logic ovf;
    ovf = (v[WN-1:W-1] != {3{v[WN-1]}});
    if (ovf) return {1'b1, v[WN-1], {(W-1){~v[WN-1]}}};
    else     return {1'b0, v[W-1:0]};
  endfunction

  logic [W:0] w_re_c;
  logic [W:0] w_im_c;

  assign w_re_c = clip(w_re_n);
  assign w_im_c = clip(w_im_n);

  logic [W-1:0] r_out_re;
  logic [W-1:0] r_out_im;
  logic         r_out_sat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_sat   <= 1'b0;
    end else if (w_en) begin
      r_out_valid <= r_s2_v;
      r_out_re    <= w_re_c[W-1:0];
      r_out_im    <= w_im_c[W-1:0];
      r_out_sat   <= w_re_c[W] | w_im_c[W];
    end
  end

  assign Real_out  = r_out_re;
  assign Imag_out  = r_out_im;
  assign out_valid = r_out_valid;
  assign sat       = r_out_sat;

endmodule

// File: tb/tb_fft_twiddle_derotator.sv
// -----------------------------------------------------------------------------
// tb_fft_twiddle_derotator
//   Directed and random stimulus for fft_twiddle_derotator (16-bit data, 16-bit
//   coefficient, C = 23170). Every accepted input pushes its model result onto
//   exp_q. Every output handshake pops the queue and compares against it.
// -----------------------------------------------------------------------------
module tb_fft_twiddle_derotator;

  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [W-1:0] Real_in;
  logic [W-1:0] Imag_in;
  logic [2:0]   rot_sel;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] Real_out;
  logic [W-1:0] Imag_out;
  logic         out_valid;
  logic         out_ready;
  logic         sat;

  fft_twiddle_derotator #(.Data_Width(W), .Coef_Width(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .Real_in   (Real_in),
    .Imag_in   (Imag_in),
    .rot_sel   (rot_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Real_out  (Real_out),
    .Imag_out  (Imag_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sat       (sat)
  );

  int n_vec  = 0;
  int n_fail = 0;
  logic [2*W:0] exp_q[$];   // {sat, re, im}

  // reference model
  function automatic longint sat16(input longint v, inout bit f);
    if (v > 32767)  begin f = 1'b1; return 32767;  end
    if (v < -32768) begin f = 1'b1; return -32768; end
    return v;
  endfunction

  function automatic logic [2*W:0] model(input int a, input int b, input int k);
    longint s, d, ps, pd, re, im;
    bit f;
    logic [63:0] re_u, im_u;
    s  = a + b;
    d  = a - b;
    ps = (s * 23170 + 16384) >>> 15;
    pd = (d * 23170 + 16384) >>> 15;
    case (k)
      0: begin re =  a;  im =  b;  end
      1: begin re =  ps; im = -pd; end
      2: begin re =  b;  im = -a;  end
      3: begin re = -pd; im = -ps; end
      4: begin re = -a;  im = -b;  end
      5: begin re = -ps; im =  pd; end
      6: begin re = -b;  im =  a;  end
      default: begin re = pd; im = ps; end
    endcase
    f    = 1'b0;
    re_u = sat16(re, f);
    im_u = sat16(im, f);
    return {f, re_u[W-1:0], im_u[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // scoreboard: handshakes evaluated mid-cycle, they complete on the next edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $error("FAIL sb_unexpected observed=%0h expected=none", {sat, Real_out, Imag_out});
        end else begin
          check("sb_out", {sat, Real_out, Imag_out}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(model($signed(Real_in), $signed(Imag_in), int'(rot_sel)));
    end
  end

  // driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int k, input bit rnd_ready);
    logic [31:0] av, bv, kv;
    logic        w;
    int          guard;
    av = a; bv = b; kv = k;
    Real_in  = av[W-1:0];
    Imag_in  = bv[W-1:0];
    rot_sel  = kv[2:0];
    in_valid = 1'b1;
    guard    = 0;
    forever begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      #1;
      w = in_ready;
      tick();
      guard++;
      if (w) break;
      if (guard > 1000) begin
        n_vec++;
        n_fail++;
        $error("FAIL send_timeout observed=stalled expected=accepted");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // single sample through an idle pipe, constant expected result and latency
  task automatic send_check(input string tag, input int a, input int b, input int k,
                            input int er, input int ei, input bit es);
    logic [31:0] eru, eiu;
    eru = er; eiu = ei;
    out_ready = 1'b1;
    send(a, b, k, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1);
    tick();
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check(tag, {sat, Real_out, Imag_out}, {es, eru[W-1:0], eiu[W-1:0]});
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    check(tag, exp_q.size(), 0);
  endtask

  function automatic int pick();
    int r;
    r = $urandom_range(0, 7);
    case (r)
      0: return -32768;
      1: return 32767;
      2: return -32767;
      3: return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   idx;
    logic w;

    rst = 1'b1; Real_in = '0; Imag_in = '0; rot_sel = '0;
    in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_real", Real_out, 0);
    check("rst_imag", Imag_out, 0);
    check("rst_sat", sat, 0);
    check("rst_in_ready", in_ready, 1);

    // directed values
    send_check("k0_pass",   1000,   -200, 0, 1000,  -200, 1'b0);
    send_check("k1",        1000,      0, 1,  707,  -707, 1'b0);
    send_check("k2",        1000,      0, 2,    0, -1000, 1'b0);
    send_check("k6",        1000,      0, 6,    0,  1000, 1'b0);
    send_check("k4_min",  -32768,      5, 4, 32767,   -5, 1'b1);
    send_check("k7_max",   32767,  32767, 7,    0, 32767, 1'b1);
    send_check("k1_neg",   -1000,      0, 1, -707,   707, 1'b0);
    send_check("k3",        1000,      0, 3, -707,  -707, 1'b0);
    send_check("k5",        1000,      0, 5, -707,   707, 1'b0);
    send_check("k2_min",  -32768,      0, 2,    0, 32767, 1'b1);
    drain("drain_directed");

    // backpressure: 6 samples, out_ready low for the first 8 cycles
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 60 && idx < 6; c++) begin
      if (c == 8) out_ready = 1'b1;
      Real_in  = 16'(1000 * idx - 2500);
      Imag_in  = 16'(700 - 300 * idx);
      rot_sel  = 3'(idx);
      in_valid = 1'b1;
      #1;
      if (c >= 3 && c < 8) begin
        check("bp_in_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold", {sat, Real_out, Imag_out}, exp_q[0]);
      end
      w = in_ready;
      tick();
      if (w) idx++;
    end
    in_valid = 1'b0;
    check("bp_all_sent", idx, 6);
    drain("drain_bp");

    // reset with 3 samples in flight and out_valid high
    out_ready = 1'b0;
    send(  123, -456, 1, 1'b0);
    send(-7000, 3000, 4, 1'b0);
    send(32767,  -32768, 7, 1'b0);
    check("rst_pre_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_real", Real_out, 0);
    check("rst2_imag", Imag_out, 0);
    check("rst2_sat", sat, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("rst2_no_stale", out_valid, 0);
    end
    send_check("post_rst", 1000, 0, 3, -707, -707, 1'b0);
    drain("drain_rst");

    // random traffic with random backpressure
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid  = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        tick();
      end
      send(pick(), pick(), int'($urandom_range(0, 7)), 1'b1);
    end
    drain("drain_random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
